// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA scanout block.
package vga_pkg;

    // Fetch controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned RGB_W    = 12;
    localparam int unsigned PIX0_LSB = 0;
    localparam int unsigned PIX1_LSB = 16;

    // Select the first (half=0) or second (half=1) RGB444 pixel of a word
    function automatic logic [RGB_W-1:0] pick_pixel(input logic [WORD_W-1:0] word,
                                                    input logic half);
        return half ? word[PIX1_LSB +: RGB_W] : word[PIX0_LSB +: RGB_W];
    endfunction

endpackage

// File: rtl/scanout_fifo.sv
// Synchronous first-word-fallthrough FIFO with flush, used to buffer pixel words.
module scanout_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy; flush behaves like reset
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/vga_scanout.sv
// VGA framebuffer scanout: Wishbone read master feeding a pixel FIFO, two RGB444 pixels per word.
// Optional build macro VGA_SCANOUT_UNDERFLOW_CNT_EN enables the saturating underflow counter.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned FB_MSB     = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [31:0]       fb_base,
    input  logic [FB_MSB:0]   frame_words,
    input  logic              frame_start,
    input  logic              pix_req,
    output logic [RGB_W-1:0]  pix_rgb,
    output logic              underflow,
    output logic [15:0]       underflow_count,
    output logic [31:0]       wbm_adr_o,
    input  logic [31:0]       wbm_dat_i,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [3:0]        wbm_sel_o,
    input  logic              wbm_ack_i
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned IW = FB_MSB + 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IW-1:0]    r_word_idx;
    logic [IW-1:0]    w_word_idx_nxt;
    logic             r_cyc;
    logic             w_cyc_nxt;
    logic [31:0]      r_adr;
    logic [31:0]      w_adr_nxt;
    logic             w_push;
    logic             w_flush;
    logic             w_more;
    logic             w_has_room;

    logic [WORD_W-1:0] w_head;
    logic [CW-1:0]     w_count;
    logic              w_full;
    logic              w_empty;

    logic              r_half;
    logic [RGB_W-1:0]  r_pix;
    logic              r_underflow;
    logic              w_serve;
    logic              w_starve;
    logic              w_pop;

    assign w_more     = (r_word_idx < frame_words);
    assign w_has_room = (w_count < CW'(FIFO_DEPTH));

    // Frame start never serves or starves; a flush cycle starves any request
    assign w_serve  = pix_req && !frame_start && !w_empty && !w_flush;
    assign w_starve = pix_req && !frame_start && (w_empty || w_flush);
    assign w_pop    = w_serve && r_half;

    scanout_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_flush (w_flush),
        .i_push  (w_push && !w_full),
        .i_data  (wbm_dat_i),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Fetch controller state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Fetch controller next state, bus request and FIFO push/flush
    always_comb begin
        w_state_nxt    = r_state;
        w_word_idx_nxt = r_word_idx;
        w_cyc_nxt      = r_cyc;
        w_adr_nxt      = r_adr;
        w_push         = 1'b0;
        w_flush        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (frame_start) begin
                    w_flush        = 1'b1;
                    w_word_idx_nxt = '0;
                end else if (!w_more) begin
                    w_state_nxt = ST_DONE;
                end else if (enable && w_has_room) begin
                    w_state_nxt = ST_FETCH;
                    w_cyc_nxt   = 1'b1;
                    w_adr_nxt   = fb_base + 32'({r_word_idx, 2'b00});
                end
            end
            ST_FETCH: begin
                if (wbm_ack_i) begin
                    w_cyc_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                    if (frame_start) begin
                        w_flush        = 1'b1;
                        w_word_idx_nxt = '0;
                    end else begin
                        w_push         = 1'b1;
                        w_word_idx_nxt = r_word_idx + IW'(1);
                    end
                end else if (frame_start) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (wbm_ack_i) begin
                    w_cyc_nxt      = 1'b0;
                    w_state_nxt    = ST_IDLE;
                    w_flush        = 1'b1;
                    w_word_idx_nxt = '0;
                end
            end
            ST_DONE: begin
                if (frame_start) begin
                    w_state_nxt    = ST_IDLE;
                    w_flush        = 1'b1;
                    w_word_idx_nxt = '0;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Registered bus outputs and word index
    always_ff @(posedge clk) begin
        if (reset) begin
            r_word_idx <= '0;
            r_cyc      <= 1'b0;
            r_adr      <= '0;
        end else begin
            r_word_idx <= w_word_idx_nxt;
            r_cyc      <= w_cyc_nxt;
            r_adr      <= w_adr_nxt;
        end
    end

    // Pixel output stage: one-cycle latency, zero when idle or starved
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pix       <= '0;
            r_underflow <= 1'b0;
            r_half      <= 1'b0;
        end else begin
            r_pix       <= w_serve ? pick_pixel(w_head, r_half) : '0;
            r_underflow <= w_starve;
            if (w_flush)      r_half <= 1'b0;
            else if (w_serve) r_half <= ~r_half;
        end
    end

`ifdef VGA_SCANOUT_UNDERFLOW_CNT_EN
    logic [15:0] r_ucnt;

    // Saturating starvation counter, cleared each frame
    always_ff @(posedge clk) begin
        if (reset || frame_start)                r_ucnt <= '0;
        else if (w_starve && r_ucnt != 16'hFFFF) r_ucnt <= r_ucnt + 16'd1;
    end

    assign underflow_count = r_ucnt;
`else
    assign underflow_count = 16'h0000;
`endif

    assign pix_rgb   = r_pix;
    assign underflow = r_underflow;
    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_cyc;
    assign wbm_adr_o = r_adr;
    assign wbm_we_o  = 1'b0;
    assign wbm_sel_o = 4'hF;

endmodule
